// File: rtl/ql_ser_tx.sv
// ql_ser_tx: QL-style serial transmitter for the ZX8302 SER1/SER2 transmit path.
// Frame format is 1 start bit, 8 data bits LSB first, then 1 or 2 stop bits.
// A one-byte holding register sits in front of the shifter. The sticky ovr flag
// records writes that arrive while the holding register is full. The cts input
// gates frame starts, and brk forces the line low without disturbing the frame machine.
module ql_ser_tx #(
  parameter int unsigned CLK_HZ = 21000000,
  parameter int unsigned STOP2  = 1
) (
  input  logic       clk_sys,
  input  logic       RESET,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic [2:0] baud_sel,
  input  logic       cts,
  input  logic       brk,
  output logic       txd,
  output logic       hold_empty,
  output logic       busy,
  output logic       ovr
);

  function automatic int unsigned div_of(input int unsigned sel);
    int unsigned baud;
    case (sel)
      0:       baud = 19200;
      1:       baud = 9600;
      2:       baud = 4800;
      3:       baud = 2400;
      4:       baud = 1200;
      5:       baud = 600;
      6:       baud = 300;
      default: baud = 75;
    endcase
    return (CLK_HZ + baud / 2) / baud;
  endfunction

  // The slowest rate sets the timer width. The table holds DIV-1 because the
  // timer reloads with DIV-1 and counts down to 0.
  localparam int TW = $clog2(div_of(7));
  localparam logic [TW-1:0] DIVM1 [8] = '{
    TW'(div_of(0) - 1), TW'(div_of(1) - 1), TW'(div_of(2) - 1), TW'(div_of(3) - 1),
    TW'(div_of(4) - 1), TW'(div_of(5) - 1), TW'(div_of(6) - 1), TW'(div_of(7) - 1)
  };

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] divm1_q, divm1_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_empty_q, hold_empty_d;
  logic          ovr_q, ovr_d;
  logic          stop2_q, stop2_d;
  logic          line_q, line_d;
  logic          txd_q, txd_d;
  logic          start;
  logic          tmr_zero;

  assign tmr_zero = (timer_q == '0);

  // Frame machine, holding register and output line next-state logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    divm1_d      = divm1_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    ovr_d        = ovr_q;
    stop2_d      = stop2_q;
    line_d       = line_q;
    start        = 1'b0;

    case (state_q)
      S_IDLE: begin
        line_d = 1'b1;
        if (!hold_empty_q && cts && !brk) begin
          start   = 1'b1;
          shift_d = hold_q;
          divm1_d = DIVM1[baud_sel];
          timer_d = DIVM1[baud_sel];
          line_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tmr_zero) begin
          line_d   = shift_q[0];
          bitcnt_d = 3'd0;
          timer_d  = divm1_q;
          state_d  = S_DATA;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DATA: begin
        if (tmr_zero) begin
          timer_d = divm1_q;
          if (bitcnt_q != 3'd7) begin
            shift_d  = {1'b0, shift_q[7:1]};
            line_d   = shift_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end else begin
            line_d  = 1'b1;
            stop2_d = 1'b0;
            state_d = S_STOP;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        // The second stop bit reuses the same timer reload.
        if (tmr_zero) begin
          if (STOP2 != 0 && !stop2_q) begin
            stop2_d = 1'b1;
            timer_d = divm1_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase

    // When a write coincides with a transfer, the shifter takes the old byte
    // and the new byte lands in the freed holding register.
    if (wr) begin
      if (hold_empty_q || start) begin
        hold_d       = din;
        hold_empty_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (start) begin
      hold_empty_d = 1'b1;
    end

    txd_d = brk ? 1'b0 : line_d;
  end

  // State registers with synchronous, active-high reset.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      divm1_q      <= '0;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'd0;
      hold_q       <= 8'd0;
      hold_empty_q <= 1'b1;
      ovr_q        <= 1'b0;
      stop2_q      <= 1'b0;
      line_q       <= 1'b1;
      txd_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      divm1_q      <= divm1_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      ovr_q        <= ovr_d;
      stop2_q      <= stop2_d;
      line_q       <= line_d;
      txd_q        <= txd_d;
    end
  end

  assign txd        = txd_q;
  assign hold_empty = hold_empty_q;
  assign busy       = (state_q != S_IDLE);
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_ql_ser_tx.sv
// tb_ql_ser_tx: scoreboard bench for ql_ser_tx at CLK_HZ=192000 (19200 baud -> 10 clocks/bit).
// Stimulus pushes the expected frames (byte, bit length, start cycle). A monitor
// decodes txd, pops the scoreboard and checks every sample of every bit.
module tb_ql_ser_tx;
  localparam int unsigned CLK_HZ = 192000;

  logic       clk_sys = 1'b0;
  logic       RESET = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] baud_sel = 3'd0;
  logic       cts = 1'b1;
  logic       brk = 1'b0;
  logic       txd, hold_empty, busy, ovr;

  ql_ser_tx #(.CLK_HZ(CLK_HZ), .STOP2(1)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .wr(wr), .din(din), .baud_sel(baud_sel),
    .cts(cts), .brk(brk), .txd(txd), .hold_empty(hold_empty), .busy(busy), .ovr(ovr)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         exp_start;
  } frame_t;

  frame_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Present a byte for one clock. A nonzero div queues the expected frame.
  task automatic send(input logic [7:0] d, input int div, input int exp_start);
    wr  = 1'b1;
    din = d;
    if (div > 0) sb.push_back('{d, div, exp_start});
    @(negedge clk_sys);
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while ((busy || !hold_empty || sb.size() != 0) && n < budget);
    chk("idle_within_budget", int'(n < budget), 1);
    if (n >= budget) sb.delete();
    @(negedge clk_sys);
  endtask

  // Monitor: decode each frame on txd and compare against the scoreboard.
  initial begin : monitor
    frame_t      e;
    logic [10:0] bits;
    int          bad;
    forever begin
      @(negedge clk_sys);
      if (mon_en && !RESET && txd === 1'b0) begin
        chk("frame_expected", int'(sb.size() != 0), 1);
        if (sb.size() == 0) begin
          for (int k = 0; k < 3000 && txd === 1'b0; k++) @(negedge clk_sys);
        end else begin
          e = sb.pop_front();
          if (e.exp_start >= 0)
            chk($sformatf("start_cycle_%02h", e.data), cyc, e.exp_start);
          bits = {2'b11, e.data, 1'b0};
          for (int b = 0; b < 11; b++) begin
            bad = 0;
            for (int s = 0; s < e.div; s++) begin
              if (!(b == 0 && s == 0)) @(negedge clk_sys);
              if (txd !== bits[b]) bad++;
            end
            chk($sformatf("frame_%02h_bit%0d_bad_samples", e.data, b), bad, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c, r, bc, n, bad;
    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("reset_txd", txd, 1);
    chk("reset_hold_empty", hold_empty, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ovr", ovr, 0);
    RESET = 1'b0;
    @(negedge clk_sys);

    // 1. Single byte, busy length
    c = cyc;
    send(8'hA5, 10, c + 2);
    bc = 0; n = 0;
    while (!busy && n < 10) begin @(negedge clk_sys); n++; end
    while (busy && n < 500) begin bc++; @(negedge clk_sys); n++; end
    chk("busy_clocks", bc, 110);
    wait_idle(100);

    // 2. Back-to-back: second byte written while the first is in DATA
    c = cyc;
    send(8'h00, 10, c + 2);
    repeat (28) @(negedge clk_sys);
    send(8'hFF, 10, c + 113);
    wait_idle(400);
    chk("b2b_ovr", ovr, 0);

    // 3. Overrun: three consecutive writes while idle
    c = cyc;
    wr = 1'b1; din = 8'h11; sb.push_back('{8'h11, 10, c + 2});
    @(negedge clk_sys);
    din = 8'h22; sb.push_back('{8'h22, 10, c + 113});
    @(negedge clk_sys);
    din = 8'h33;
    @(negedge clk_sys);
    wr = 1'b0;
    chk("overrun_ovr_set", ovr, 1);
    chk("overrun_hold_full", hold_empty, 0);
    wait_idle(400);
    chk("overrun_ovr_sticky", ovr, 1);

    // 4. CTS hold, then cts drop mid-frame
    cts = 1'b0;
    send(8'h55, 0, 0);
    bad = 0;
    repeat (500) begin
      @(negedge clk_sys);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("cts_hold_line_idle", bad, 0);
    chk("cts_hold_byte_held", hold_empty, 0);
    r = cyc;
    cts = 1'b1;
    sb.push_back('{8'h55, 10, r + 1});
    repeat (40) @(negedge clk_sys);
    cts = 1'b0;
    wait_idle(300);
    cts = 1'b1;

    // 5. Baud 9600 (20 clocks/bit), baud change mid-frame, then 19200 again
    baud_sel = 3'd1;
    c = cyc;
    send(8'h3C, 20, c + 2);
    repeat (50) @(negedge clk_sys);
    baud_sel = 3'd0;
    wait_idle(500);
    c = cyc;
    send(8'h81, 10, c + 2);
    wait_idle(300);

    // 5b. Break mid-DATA, then break blocking a frame start
    mon_en = 1'b0;
    send(8'hFF, 0, 0);
    repeat (34) @(negedge clk_sys);
    brk = 1'b1;
    @(negedge clk_sys);
    chk("brk_txd_low", txd, 0);
    chk("brk_busy_kept", busy, 1);
    repeat (4) @(negedge clk_sys);
    chk("brk_txd_held_low", txd, 0);
    brk = 1'b0;
    @(negedge clk_sys);
    chk("brk_release_txd", txd, 1);
    wait_idle(300);
    brk = 1'b1;
    send(8'h12, 0, 0);
    repeat (20) @(negedge clk_sys);
    chk("brk_block_busy", busy, 0);
    chk("brk_block_hold", hold_empty, 0);
    chk("brk_block_txd", txd, 0);
    brk = 1'b0;
    @(negedge clk_sys);
    chk("brk_unblock_busy", busy, 1);
    chk("brk_unblock_start", txd, 0);
    chk("brk_unblock_hold", hold_empty, 1);
    wait_idle(300);
    chk("brk_frame_end_txd", txd, 1);

    // 6. Reset mid-frame with a byte held
    chk("pre_reset_ovr", ovr, 1);
    send(8'h99, 0, 0);
    repeat (3) @(negedge clk_sys);
    send(8'h66, 0, 0);
    repeat (30) @(negedge clk_sys);
    chk("pre_reset_hold_full", hold_empty, 0);
    RESET = 1'b1;
    @(negedge clk_sys);
    chk("midreset_txd", txd, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_hold_empty", hold_empty, 1);
    chk("midreset_ovr", ovr, 0);
    RESET = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk_sys);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    mon_en = 1'b1;
    c = cyc;
    send(8'hC3, 10, c + 2);
    wait_idle(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
